// File: rtl/rvv_backend_uop_queue.sv
// Multi-push / multi-pop circular uop queue between the RVV decoder and dispatch.
// Optional RVV_UOPQ_ERR_CHECK_EN adds a sticky protocol-error output plus SVA.
module rvv_backend_uop_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_PUSH  = 4,
  parameter int unsigned NUM_POP   = 4,
  parameter int unsigned UOP_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PUSH-1:0]             push_de2uq,
  input  logic [NUM_PUSH*UOP_WIDTH-1:0]   data_de2uq,
  output logic                            fifo_full_uq2de,
  output logic [NUM_PUSH-1:0]             fifo_almost_full_uq2de,
  input  logic [NUM_POP-1:0]              pop_uq2dp,
  output logic [NUM_POP*UOP_WIDTH-1:0]    data_uq2dp,
  output logic                            fifo_empty_uq2dp,
  output logic [NUM_POP-1:0]              fifo_almost_empty_uq2dp,
  output logic [$clog2(DEPTH):0]          uop_count,
  input  logic                            trap_flush_rvv
`ifdef RVV_UOPQ_ERR_CHECK_EN
  ,
  output logic                            err_uq
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [UOP_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d, free;
  logic [CW-1:0]        n_push_req, n_pop_req, n_push, n_pop;
  logic                 push_run, pop_run;

  // Accepted lanes are the leading run of ones from bit 0.
  always_comb begin
    n_push_req = '0;
    push_run   = 1'b1;
    for (int k = 0; k < NUM_PUSH; k++) begin
      push_run = push_run & push_de2uq[k];
      if (push_run) n_push_req = n_push_req + CW'(1);
    end
    n_pop_req = '0;
    pop_run   = 1'b1;
    for (int k = 0; k < NUM_POP; k++) begin
      pop_run = pop_run & pop_uq2dp[k];
      if (pop_run) n_pop_req = n_pop_req + CW'(1);
    end
  end

  // Both caps use start-of-cycle occupancy, so a pop never frees room for a same-cycle push.
  assign free   = CW'(DEPTH) - count_q;
  assign n_push = (n_push_req > free) ? free : n_push_req;
  assign n_pop  = (n_pop_req > count_q) ? count_q : n_pop_req;

  always_comb begin
    wptr_d  = wptr_q + PW'(n_push);
    rptr_d  = rptr_q + PW'(n_pop);
    count_d = count_q + n_push - n_pop;
    if (trap_flush_rvv) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !trap_flush_rvv) begin
      for (int k = 0; k < NUM_PUSH; k++) begin
        if (CW'(k) < n_push) mem[wptr_q + PW'(k)] <= data_de2uq[k*UOP_WIDTH +: UOP_WIDTH];
      end
    end
  end

  always_comb begin
    data_uq2dp = '0;
    for (int k = 0; k < NUM_POP; k++) begin
      data_uq2dp[k*UOP_WIDTH +: UOP_WIDTH] = mem[rptr_q + PW'(k)];
      fifo_almost_empty_uq2dp[k] = count_q < CW'(k + 1);
    end
    for (int k = 0; k < NUM_PUSH; k++) begin
      fifo_almost_full_uq2de[k] = free < CW'(k + 1);
    end
  end

  assign fifo_full_uq2de  = fifo_almost_full_uq2de[0];
  assign fifo_empty_uq2dp = fifo_almost_empty_uq2dp[0];
  assign uop_count        = count_q;

`ifdef RVV_UOPQ_ERR_CHECK_EN
  logic push_bad, pop_bad, err_cond, err_q;

  // A set bit above a clear bit means the vector is not a thermometer code.
  always_comb begin
    push_bad = 1'b0;
    for (int k = 1; k < NUM_PUSH; k++) begin
      if (push_de2uq[k] && !push_de2uq[k-1]) push_bad = 1'b1;
    end
    pop_bad = 1'b0;
    for (int k = 1; k < NUM_POP; k++) begin
      if (pop_uq2dp[k] && !pop_uq2dp[k-1]) pop_bad = 1'b1;
    end
    err_cond = !trap_flush_rvv &&
               (push_bad || pop_bad || (n_push_req > free) || (n_pop_req > count_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_cond) begin
      err_q <= 1'b1;
    end
  end

  assign err_uq = err_q;

  a_no_protocol_err: assert property (@(posedge clk) disable iff (rst) !err_cond);
`endif

endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// Self-checking bench for rvv_backend_uop_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_rvv_backend_uop_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NP    = 4;
  localparam int unsigned W     = 64;
  localparam int unsigned CW    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     push_de2uq = '0;
  logic [NP*W-1:0]   data_de2uq = '0;
  logic              fifo_full_uq2de;
  logic [NP-1:0]     fifo_almost_full_uq2de;
  logic [NP-1:0]     pop_uq2dp = '0;
  logic [NP*W-1:0]   data_uq2dp;
  logic              fifo_empty_uq2dp;
  logic [NP-1:0]     fifo_almost_empty_uq2dp;
  logic [CW-1:0]     uop_count;
  logic              trap_flush_rvv = 1'b0;

  rvv_backend_uop_queue #(
    .DEPTH     (DEPTH),
    .NUM_PUSH  (NP),
    .NUM_POP   (NP),
    .UOP_WIDTH (W)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .push_de2uq              (push_de2uq),
    .data_de2uq              (data_de2uq),
    .fifo_full_uq2de         (fifo_full_uq2de),
    .fifo_almost_full_uq2de  (fifo_almost_full_uq2de),
    .pop_uq2dp               (pop_uq2dp),
    .data_uq2dp              (data_uq2dp),
    .fifo_empty_uq2dp        (fifo_empty_uq2dp),
    .fifo_almost_empty_uq2dp (fifo_almost_empty_uq2dp),
    .uop_count               (uop_count),
    .trap_flush_rvv          (trap_flush_rvv)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mdl[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int lead_ones(input logic [NP-1:0] v);
    int n = 0;
    while (n < NP && v[n]) n++;
    return n;
  endfunction

  function automatic logic [NP-1:0] exp_ae(input int size);
    logic [NP-1:0] r;
    for (int k = 0; k < NP; k++) r[k] = (size < k + 1);
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_af(input int size);
    logic [NP-1:0] r;
    for (int k = 0; k < NP; k++) r[k] = ((DEPTH - size) < k + 1);
    return r;
  endfunction

  // Called at a negedge; runs one clock with the given inputs and updates the model.
  task automatic apply(input logic [NP-1:0] push, input logic [NP-1:0] pop, input logic flush);
    logic [NP*W-1:0] d;
    int np, nq, size;
    for (int k = 0; k < NP; k++) d[k*W +: W] = {$urandom(), $urandom()};
    push_de2uq = push;
    pop_uq2dp = pop;
    trap_flush_rvv = flush;
    data_de2uq = d;
    @(posedge clk);
    if (flush) begin
      mdl.delete();
    end else begin
      size = mdl.size();
      np = lead_ones(push);
      if (np > DEPTH - size) np = DEPTH - size;
      nq = lead_ones(pop);
      if (nq > size) nq = size;
      for (int k = 0; k < nq; k++) void'(mdl.pop_front());
      for (int k = 0; k < np; k++) mdl.push_back(d[k*W +: W]);
    end
    @(negedge clk);
    push_de2uq = '0;
    pop_uq2dp = '0;
    trap_flush_rvv = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl.delete();
    n_cmp += 5;
    if (uop_count !== 5'd0) begin
      $display("FAIL reset_count got %0d want 0", uop_count); n_err++;
    end
    if (fifo_empty_uq2dp !== 1'b1) begin
      $display("FAIL reset_empty got %b want 1", fifo_empty_uq2dp); n_err++;
    end
    if (fifo_almost_empty_uq2dp !== 4'b1111) begin
      $display("FAIL reset_ae got %b want 1111", fifo_almost_empty_uq2dp); n_err++;
    end
    if (fifo_full_uq2de !== 1'b0) begin
      $display("FAIL reset_full got %b want 0", fifo_full_uq2de); n_err++;
    end
    if (fifo_almost_full_uq2de !== 4'b0000) begin
      $display("FAIL reset_af got %b want 0000", fifo_almost_full_uq2de); n_err++;
    end
  endtask

  task automatic test_push_pop;
    logic [W-1:0] c, d;
    apply(4'b1111, 4'b0000, 1'b0);
    n_cmp++;
    if (uop_count !== 5'd4) begin
      $display("FAIL pp_count4 got %0d want 4", uop_count); n_err++;
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (data_uq2dp[k*W +: W] !== mdl[k]) begin
        $display("FAIL pp_data%0d got %h want %h", k, data_uq2dp[k*W +: W], mdl[k]); n_err++;
      end
    end
    c = mdl[2];
    d = mdl[3];
    apply(4'b0000, 4'b0011, 1'b0);
    n_cmp += 4;
    if (data_uq2dp[0 +: W] !== c) begin
      $display("FAIL pp_after_pop0 got %h want %h", data_uq2dp[0 +: W], c); n_err++;
    end
    if (data_uq2dp[W +: W] !== d) begin
      $display("FAIL pp_after_pop1 got %h want %h", data_uq2dp[W +: W], d); n_err++;
    end
    if (uop_count !== 5'd2) begin
      $display("FAIL pp_count2 got %0d want 2", uop_count); n_err++;
    end
    if (fifo_almost_empty_uq2dp !== 4'b1100) begin
      $display("FAIL pp_ae got %b want 1100", fifo_almost_empty_uq2dp); n_err++;
    end
    apply(4'b0000, 4'b0011, 1'b0);
  endtask

  task automatic test_full;
    repeat (3) apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b0011, 4'b0000, 1'b0);
    n_cmp++;
    if (uop_count !== 5'd14) begin
      $display("FAIL full_count14 got %0d want 14", uop_count); n_err++;
    end
    apply(4'b1111, 4'b0000, 1'b0);
    n_cmp += 3;
    if (uop_count !== 5'd16) begin
      $display("FAIL full_count16 got %0d want 16", uop_count); n_err++;
    end
    if (fifo_full_uq2de !== 1'b1) begin
      $display("FAIL full_flag got %b want 1", fifo_full_uq2de); n_err++;
    end
    if (fifo_almost_full_uq2de !== 4'b1111) begin
      $display("FAIL full_af got %b want 1111", fifo_almost_full_uq2de); n_err++;
    end
    apply(4'b0001, 4'b0001, 1'b0);
    n_cmp += 2;
    if (uop_count !== 5'd15) begin
      $display("FAIL full_pushpop_count got %0d want 15", uop_count); n_err++;
    end
    if (data_uq2dp[0 +: W] !== mdl[0]) begin
      $display("FAIL full_pushpop_head got %h want %h", data_uq2dp[0 +: W], mdl[0]); n_err++;
    end
    apply(4'b0001, 4'b0000, 1'b0);
    n_cmp++;
    if (uop_count !== 5'd16) begin
      $display("FAIL full_refill_count got %0d want 16", uop_count); n_err++;
    end
    repeat (4) apply(4'b0000, 4'b1111, 1'b0);
  endtask

  task automatic test_wrap;
    logic [W-1:0] tags [4];
    apply(4'b0000, 4'b0000, 1'b1);
    repeat (3) apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b0011, 4'b0000, 1'b0);
    repeat (3) apply(4'b0000, 4'b1111, 1'b0);
    apply(4'b0000, 4'b0011, 1'b0);
    apply(4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) tags[k] = mdl[k];
    for (int k = 0; k < 4; k++) begin
      n_cmp += 2;
      if (data_uq2dp[0 +: W] !== tags[k]) begin
        $display("FAIL wrap_data%0d got %h want %h", k, data_uq2dp[0 +: W], tags[k]); n_err++;
      end
      if (uop_count !== CW'(4 - k)) begin
        $display("FAIL wrap_count%0d got %0d want %0d", k, uop_count, 4 - k); n_err++;
      end
      apply(4'b0000, 4'b0001, 1'b0);
    end
    n_cmp++;
    if (fifo_empty_uq2dp !== 1'b1) begin
      $display("FAIL wrap_empty got %b want 1", fifo_empty_uq2dp); n_err++;
    end
  endtask

  task automatic test_flush;
    logic [W-1:0] t;
    apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b0001, 4'b0000, 1'b0);
    n_cmp++;
    if (uop_count !== 5'd9) begin
      $display("FAIL flush_pre_count got %0d want 9", uop_count); n_err++;
    end
    apply(4'b1111, 4'b0111, 1'b1);
    n_cmp += 2;
    if (uop_count !== 5'd0) begin
      $display("FAIL flush_count got %0d want 0", uop_count); n_err++;
    end
    if (fifo_empty_uq2dp !== 1'b1) begin
      $display("FAIL flush_empty got %b want 1", fifo_empty_uq2dp); n_err++;
    end
    apply(4'b0001, 4'b0000, 1'b0);
    t = mdl[0];
    n_cmp += 2;
    if (uop_count !== 5'd1) begin
      $display("FAIL flush_push_count got %0d want 1", uop_count); n_err++;
    end
    if (data_uq2dp[0 +: W] !== t) begin
      $display("FAIL flush_push_data got %h want %h", data_uq2dp[0 +: W], t); n_err++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 500; i++) begin
      apply(NP'($urandom_range(0, 15)), NP'($urandom_range(0, 15)),
            ($urandom_range(0, 31) == 0));
      n_cmp += 5;
      if (uop_count !== CW'(mdl.size())) begin
        $display("FAIL rnd_count[%0d] got %0d want %0d", i, uop_count, mdl.size()); n_err++;
      end
      if (fifo_full_uq2de !== (mdl.size() == DEPTH)) begin
        $display("FAIL rnd_full[%0d] got %b want %b", i, fifo_full_uq2de, mdl.size() == DEPTH);
        n_err++;
      end
      if (fifo_empty_uq2dp !== (mdl.size() == 0)) begin
        $display("FAIL rnd_empty[%0d] got %b want %b", i, fifo_empty_uq2dp, mdl.size() == 0);
        n_err++;
      end
      if (fifo_almost_full_uq2de !== exp_af(mdl.size())) begin
        $display("FAIL rnd_af[%0d] got %b want %b", i, fifo_almost_full_uq2de,
                 exp_af(mdl.size())); n_err++;
      end
      if (fifo_almost_empty_uq2dp !== exp_ae(mdl.size())) begin
        $display("FAIL rnd_ae[%0d] got %b want %b", i, fifo_almost_empty_uq2dp,
                 exp_ae(mdl.size())); n_err++;
      end
      for (int k = 0; k < NP; k++) begin
        if (k < mdl.size()) begin
          n_cmp++;
          if (data_uq2dp[k*W +: W] !== mdl[k]) begin
            $display("FAIL rnd_data[%0d] lane %0d got %h want %h", i, k,
                     data_uq2dp[k*W +: W], mdl[k]); n_err++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_wrap();
    test_flush();
    test_random();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvv_backend_uop_queue.md
Name: rvv_backend_uop_queue

Overview:
- Multi-push, multi-pop circular FIFO of UOP_QUEUE_t entries between the RVV decoder and dispatch.
- Accepts up to NUM_PUSH uops per cycle from the decoder's push/data interface.
- Returns fifo_full and per-lane almost-full status to the decoder.
- Presents up to NUM_POP head entries to dispatch with empty and almost-empty status; cleared by trap flush.

Parameters:
- DEPTH, 16, number of entries; power of 2, at least max(NUM_PUSH, NUM_POP).
- NUM_PUSH, `NUM_DE_UOP (4), push lanes.
- NUM_POP, `NUM_DP_UOP (4), pop lanes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- push_de2uq  in  NUM_PUSH  per-lane push request; must be thermometer from bit 0.
- data_de2uq  in  NUM_PUSH x UOP_QUEUE_t  uop per push lane.
- fifo_full_uq2de  out  1  no free entry.
- fifo_almost_full_uq2de  out  NUM_PUSH  bit k set when free entries < k+1.
- pop_uq2dp  in  NUM_POP  per-lane pop request; thermometer from bit 0.
- data_uq2dp  out  NUM_POP x UOP_QUEUE_t  entry at head+k.
- fifo_empty_uq2dp  out  1  count == 0.
- fifo_almost_empty_uq2dp  out  NUM_POP  bit k set when count < k+1.
- uop_count  out  $clog2(DEPTH)+1  current occupancy.
- trap_flush_rvv  in  1  discard all contents.

Behaviour:
- State:
  - wptr and rptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
  - Storage array is not reset.
- Reset (rst=1 at edge): wptr=rptr=count=0 next cycle. Outputs then read fifo_empty=1, almost_empty all 1s, fifo_full=0, almost_full all 0s, uop_count=0. data_uq2dp is don't-care.
- Status outputs are combinational from registered count only; they never depend on the current push or pop.
  - fifo_full == fifo_almost_full[0].
  - fifo_empty == fifo_almost_empty[0].
- Push:
  - Accepted lanes: n_push = number of leading ones in push_de2uq, capped at free = DEPTH-count as sampled at the start of the cycle.
  - Lane k writes mem[wptr+k]; wptr += n_push.
  - Lanes past a zero bit, or past free, are dropped silently.
- Pop:
  - n_pop = number of leading ones in pop_uq2dp, capped at count.
  - rptr += n_pop.
  - data_uq2dp[k] = mem[rptr+k] combinationally; valid only where almost_empty[k]=0.
- Simultaneous push and pop: both are legal and are evaluated against start-of-cycle count, so there is no same-cycle bypass.
  - count_next = count + n_push - n_pop.
  - When full, a pop does not free space for a push in the same cycle.
- Latency: a pushed uop is visible on data_uq2dp[0] the cycle after the push, if the queue was empty.
- Wrap-around: lane indices wrap modulo DEPTH. A 4-wide push at wptr=DEPTH-2 writes entries DEPTH-2, DEPTH-1, 0, 1.
- Flush: trap_flush_rvv=1 overrides push and pop that cycle. Next cycle wptr=rptr=count=0, identical to reset.
- Priority: rst > trap_flush_rvv > push/pop.

Optional Feature:
- Macro RVV_UOPQ_ERR_CHECK_EN.
- When defined:
  - Adds output err_uq (1 bit, sticky).
  - err_uq sets on any of: a non-thermometer push or pop vector; a push lane beyond free; a pop lane beyond count.
  - err_uq clears only on rst; flush does not clear it.
  - Embeds SVA asserting that none of these conditions occur.
- When undefined: no port, no logic; the illegal lanes are dropped as above.

Test Plan:
- Reset, then idle: uop_count=0, fifo_empty=1, almost_empty=4'b1111, fifo_full=0, almost_full=4'b0000.
- Push 4 uops (A,B,C,D) in one cycle: next cycle uop_count=4 and data_uq2dp[0..3]=A,B,C,D. Pop 4'b0011: next cycle data_uq2dp[0..1]=C,D, uop_count=2, almost_empty=4'b1100.
- DEPTH=16, fill to count=14, push 4'b1111: only 2 lanes accepted, uop_count=16, fifo_full=1, almost_full=4'b1111. With RVV_UOPQ_ERR_CHECK_EN, err_uq=1.
- Full queue, push 4'b0001 with pop 4'b0001 in the same cycle: push dropped, pop accepted, count=15. Next cycle push 4'b0001 is accepted, count=16.
- Wrap: fill and drain to rptr=wptr=14, push 4 tagged uops, pop 4 over 4 cycles: data emerges in order from mem[14], mem[15], mem[0], mem[1].
- Count=9 with push 4'b1111 and pop 4'b0111 plus trap_flush_rvv=1: next cycle count=0, fifo_empty=1. A push the following cycle appears at data_uq2dp[0].
